// File: rtl/lfsr_scrambler_pkg.sv
// Shared types and constants for the parametrised LFSR scrambler.
package lfsr_scrambler_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_RSVD = 2'b01,
        MODE_MSCR = 2'b10,
        MODE_MDSC = 2'b11
    } mode_e;

    localparam logic [31:0] DEFAULT_TAP_MASK = 32'h0000_0063;
    localparam logic [31:0] DEFAULT_SEED_RST = 32'h0000_0001;

    function automatic logic parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR bit step for additive, multiplicative scramble and descramble modes.
module lfsr_step
    import lfsr_scrambler_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(DEFAULT_TAP_MASK)
) (
    input  logic [WIDTH-1:0] state,
    input  logic             data_bit,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_state,
    output logic             out_bit
);

    logic fb;

    always_comb begin
        fb         = parity(64'(state & TAP_MASK));
        out_bit    = data_bit ^ state[0];
        next_state = {fb, state[WIDTH-1:1]};
        case (mode_e'(mode))
            MODE_MSCR: begin
                out_bit    = data_bit ^ fb;
                next_state = {out_bit, state[WIDTH-1:1]};
            end
            MODE_MDSC: begin
                out_bit    = data_bit ^ fb;
                next_state = {data_bit, state[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lfsr_scrambler_param.sv
// Parametrised LFSR scrambler/descrambler with seed load and all-zero lockup flag.
// Define SCRAMBLER_LOCKUP_RECOVER_EN to reseed an all-zero additive state automatically.
module lfsr_scrambler_param
    import lfsr_scrambler_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(DEFAULT_TAP_MASK),
    parameter int unsigned      DATA_W   = 1,
    parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(DEFAULT_SEED_RST)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [WIDTH-1:0]  state_out,
    output logic              lockup
);

    logic [WIDTH-1:0]             state_q, state_d, start_state;
    logic [DATA_W:0][WIDTH-1:0]   chain;
    logic [DATA_W-1:0]            word_out;
    logic [DATA_W-1:0]            out_data_q, out_data_d;
    logic                         out_valid_q;
    logic                         lockup_q, lockup_d;
    logic                         additive;

    assign additive = ~mode[1];

`ifdef SCRAMBLER_LOCKUP_RECOVER_EN
    assign start_state = (additive && state_q == '0) ? SEED_RST : state_q;
`else
    assign start_state = state_q;
`endif

    assign chain[0] = start_state;

    for (genvar i = 0; i < DATA_W; i++) begin : g_step
        lfsr_step #(
            .WIDTH    (WIDTH),
            .TAP_MASK (TAP_MASK)
        ) u_step (
            .state      (chain[i]),
            .data_bit   (in_data[i]),
            .mode       (mode),
            .next_state (chain[i+1]),
            .out_bit    (word_out[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        if (seed_load) begin
            state_d = seed;
        end else if (in_valid) begin
            state_d = chain[DATA_W];
        end
        if (in_valid) begin
            out_data_d = word_out;
        end
`ifdef SCRAMBLER_LOCKUP_RECOVER_EN
        // Flag only the transition into zero so the flag is a single-cycle pulse.
        lockup_d = additive && (state_d == '0) && ((state_q != '0) || seed_load);
`else
        lockup_d = additive && (state_d == '0);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SEED_RST;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            lockup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= in_valid;
            out_data_q  <= out_data_d;
            lockup_q    <= lockup_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign state_out = state_q;
    assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_scrambler_param.sv
// Directed bench: small 4-bit additive/multiplicative vectors, 8-bit scramble/descramble loop.
module tb_lfsr_scrambler_param;

`ifdef SCRAMBLER_LOCKUP_RECOVER_EN
    localparam bit REC = 1'b1;
`else
    localparam bit REC = 1'b0;
`endif

    logic clock;
    logic reset;

    // Small instance: WIDTH=4, taps x^0 ^ x^1, one bit per cycle.
    logic [1:0] s_mode;
    logic       s_ld, s_v, s_d;
    logic [3:0] s_seed;
    logic       s_ov, s_lk;
    logic [0:0] s_od;
    logic [3:0] s_st;

    // Byte-wide default-parameter scrambler feeding a descrambler.
    logic [1:0]  a_mode, b_mode;
    logic        a_ld, a_v;
    logic [31:0] a_seed;
    logic [7:0]  a_d;
    logic        a_ov, a_lk, b_ov, b_lk;
    logic [7:0]  a_od, b_od;
    logic [31:0] a_st, b_st;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_scrambler_param #(
        .WIDTH(4), .TAP_MASK(4'b0011), .DATA_W(1), .SEED_RST(4'b0001)
    ) u_small (
        .clock(clock), .reset(reset), .mode(s_mode), .seed_load(s_ld), .seed(s_seed),
        .in_valid(s_v), .in_data(s_d), .out_valid(s_ov), .out_data(s_od),
        .state_out(s_st), .lockup(s_lk)
    );

    lfsr_scrambler_param #(.DATA_W(8)) u_scr (
        .clock(clock), .reset(reset), .mode(a_mode), .seed_load(a_ld), .seed(a_seed),
        .in_valid(a_v), .in_data(a_d), .out_valid(a_ov), .out_data(a_od),
        .state_out(a_st), .lockup(a_lk)
    );

    lfsr_scrambler_param #(.DATA_W(8), .SEED_RST(32'hDEAD_BEEF)) u_dsc (
        .clock(clock), .reset(reset), .mode(b_mode), .seed_load(1'b0), .seed(32'h0),
        .in_valid(a_ov), .in_data(a_od), .out_valid(b_ov), .out_data(b_od),
        .state_out(b_st), .lockup(b_lk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic       ld;
        logic [3:0] seed;
        logic [1:0] mode;
        logic       d;
        logic       ov;
        logic       od;
        logic [3:0] st;
        logic       lk;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(input logic v, input logic ld, input logic [3:0] seed,
                                input logic [1:0] mode, input logic d, input logic ov,
                                input logic od, input logic [3:0] st, input logic lk);
        vec_t r;
        r.v = v; r.ld = ld; r.seed = seed; r.mode = mode; r.d = d;
        r.ov = ov; r.od = od; r.st = st; r.lk = lk;
        return r;
    endfunction

    // Additive reference for the byte-wide instance: taps 0x63, bit 0 first.
    function automatic logic [39:0] ref_add(input logic [31:0] s_in, input logic [7:0] d);
        logic [31:0] s;
        logic [7:0]  o;
        logic        fb;
        s = s_in;
        o = '0;
        for (int k = 0; k < 8; k++) begin
            o[k] = d[k] ^ s[0];
            fb   = ^(s & 32'h0000_0063);
            s    = {fb, s[31:1]};
        end
        return {s, o};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0]  bytes[40];
        logic [31:0] model;
        logic [7:0]  exp_o;
        logic        have_o;
        logic        v;
        logic [7:0]  d;

        tbl[0]  = mk(1, 0, 4'h0, 2'b00, 0, 1, 1, 4'b1000, 0);
        tbl[1]  = mk(1, 0, 4'h0, 2'b00, 0, 1, 0, 4'b0100, 0);
        tbl[2]  = mk(1, 0, 4'h0, 2'b00, 0, 1, 0, 4'b0010, 0);
        tbl[3]  = mk(1, 0, 4'h0, 2'b00, 0, 1, 0, 4'b1001, 0);
        tbl[4]  = mk(1, 0, 4'h0, 2'b00, 0, 1, 1, 4'b1100, 0);
        tbl[5]  = mk(1, 0, 4'h0, 2'b00, 0, 1, 0, 4'b0110, 0);
        tbl[6]  = mk(1, 0, 4'h0, 2'b00, 0, 1, 0, 4'b1011, 0);
        tbl[7]  = mk(1, 0, 4'h0, 2'b00, 0, 1, 1, 4'b0101, 0);
        tbl[8]  = mk(1, 0, 4'h0, 2'b00, 0, 1, 1, 4'b1010, 0);
        tbl[9]  = mk(1, 0, 4'h0, 2'b00, 0, 1, 0, 4'b1101, 0);
        tbl[10] = mk(1, 0, 4'h0, 2'b00, 0, 1, 1, 4'b1110, 0);
        tbl[11] = mk(1, 0, 4'h0, 2'b00, 0, 1, 0, 4'b1111, 0);
        tbl[12] = mk(1, 0, 4'h0, 2'b00, 0, 1, 1, 4'b0111, 0);
        tbl[13] = mk(1, 0, 4'h0, 2'b00, 0, 1, 1, 4'b0011, 0);
        tbl[14] = mk(1, 0, 4'h0, 2'b00, 0, 1, 1, 4'b0001, 0);
        tbl[15] = mk(0, 0, 4'h0, 2'b00, 0, 0, 1, 4'b0001, 0);
        tbl[16] = mk(1, 0, 4'h0, 2'b01, 1, 1, 0, 4'b1000, 0);
        tbl[17] = mk(1, 1, 4'h0, 2'b00, 1, 1, 1, 4'b0000, 1);
        tbl[18] = mk(0, 0, 4'h0, 2'b00, 0, 0, 1, 4'b0000, !REC);
        tbl[19] = mk(1, 0, 4'h0, 2'b00, 1, 1, !REC, REC ? 4'b1000 : 4'b0000, !REC);
        tbl[20] = mk(0, 0, 4'h0, 2'b10, 0, 0, !REC, REC ? 4'b1000 : 4'b0000, 0);
        tbl[21] = mk(0, 1, 4'hA, 2'b00, 0, 0, !REC, 4'b1010, 0);
        tbl[22] = mk(1, 0, 4'h0, 2'b10, 1, 1, 0, 4'b0101, 0);
        tbl[23] = mk(1, 0, 4'h0, 2'b10, 0, 1, 1, 4'b1010, 0);
        tbl[24] = mk(1, 0, 4'h0, 2'b11, 1, 1, 0, 4'b1101, 0);
        tbl[25] = mk(1, 0, 4'h0, 2'b11, 0, 1, 1, 4'b0110, 0);
        tbl[26] = mk(1, 1, 4'h0, 2'b11, 1, 1, 0, 4'b0000, 0);
        tbl[27] = mk(1, 0, 4'h0, 2'b11, 1, 1, 1, 4'b1000, 0);
        tbl[28] = mk(1, 0, 4'h0, 2'b00, 0, 1, 0, 4'b0100, 0);

        reset = 1'b1;
        s_mode = 2'b00; s_ld = 0; s_v = 0; s_d = 0; s_seed = '0;
        a_mode = 2'b10; b_mode = 2'b11; a_ld = 0; a_v = 0; a_d = '0; a_seed = '0;
        tick();
        tick();
        check("rst.ov", 64'(s_ov), 64'd0);
        check("rst.od", 64'(s_od), 64'd0);
        check("rst.st", 64'(s_st), 64'h1);
        check("rst.lk", 64'(s_lk), 64'd0);
        check("rst.big_st", 64'(a_st), 64'h1);
        reset = 1'b0;

        for (int i = 0; i < 29; i++) begin
            s_v = tbl[i].v; s_ld = tbl[i].ld; s_seed = tbl[i].seed;
            s_mode = tbl[i].mode; s_d = tbl[i].d;
            tick();
            check($sformatf("tbl[%0d].ov", i), 64'(s_ov), 64'(tbl[i].ov));
            check($sformatf("tbl[%0d].od", i), 64'(s_od), 64'(tbl[i].od));
            check($sformatf("tbl[%0d].st", i), 64'(s_st), 64'(tbl[i].st));
            check($sformatf("tbl[%0d].lk", i), 64'(s_lk), 64'(tbl[i].lk));
        end
        s_v = 0; s_ld = 0;

        // Scramble -> descramble loop; descrambler self-synchronises after 32 bits.
        for (int i = 0; i < 40; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            a_v = 1'b1;
            a_d = bytes[i];
            tick();
            if (i >= 1) check($sformatf("loop[%0d].ov", i), 64'(b_ov), 64'd1);
            if (i >= 5) check($sformatf("loop[%0d].data", i - 1), 64'(b_od), 64'(bytes[i-1]));
        end
        a_v = 1'b0;
        tick();
        check("loop.last", 64'(b_od), 64'(bytes[39]));
        check("loop.state_sync", 64'(b_st), 64'(a_st));
        check("loop.lk", 64'({a_lk, b_lk}), 64'd0);

        // Additive mode with random gaps against the reference model.
        a_mode = 2'b00;
        a_ld = 1'b1;
        a_seed = 32'h1234_5678;
        tick();
        a_ld = 1'b0;
        check("gap.seed", 64'(a_st), 64'h1234_5678);
        model = 32'h1234_5678;
        exp_o = '0;
        have_o = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 2) != 0);
            d = 8'($urandom);
            a_v = v;
            a_d = d;
            if (v) begin
                {model, exp_o} = ref_add(model, d);
                have_o = 1'b1;
            end
            tick();
            check($sformatf("gap[%0d].ov", i), 64'(a_ov), 64'(v));
            check($sformatf("gap[%0d].st", i), 64'(a_st), 64'(model));
            if (have_o) check($sformatf("gap[%0d].od", i), 64'(a_od), 64'(exp_o));
        end
        a_v = 1'b0;
        check("gap.lk", 64'(a_lk), 64'd0);

        // Reset mid-stream while locked up and with a valid word in flight.
        s_mode = 2'b00; s_v = 1'b1; s_d = 1'b0;
        tick();
        tick();
        tick();
        s_ld = 1'b1; s_seed = 4'b0000; s_d = 1'b1;
        tick();
        s_ld = 1'b0;
        check("mid.lk_before", 64'(s_lk), 64'd1);
        reset = 1'b1;
        tick();
        check("mid.ov", 64'(s_ov), 64'd0);
        check("mid.od", 64'(s_od), 64'd0);
        check("mid.st", 64'(s_st), 64'h1);
        check("mid.lk", 64'(s_lk), 64'd0);
        reset = 1'b0;
        s_v = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
